// File: rtl/albacore_run_monitor.sv
// Run-control and profiling monitor: starts a run, counts cycles/fetches/events, halts on QUIT or timeout.
// Latency: all outputs registered, RUN one edge after start, DONE HALT_DELAY edges after QUIT; no backpressure.
module albacore_run_monitor #(
  parameter int                 STATE_W     = 5,
  parameter logic [STATE_W-1:0] IFETCH_CODE = 5'd0,
  parameter logic [STATE_W-1:0] QUIT_CODE   = 5'd18,
  parameter int                 HALT_DELAY  = 1,
  parameter int                 TIMEOUT     = 0,
  parameter int                 CNT_W       = 32,
  parameter int                 N_EVT       = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [STATE_W-1:0]     cpu_state,
  input  logic                   start,
  input  logic [N_EVT-1:0]       evt,
  output logic                   running,
  output logic                   done,
  output logic                   timed_out,
  output logic                   halt_req,
  output logic [CNT_W-1:0]       cycle_count,
  output logic [CNT_W-1:0]       instr_count,
  output logic [N_EVT*CNT_W-1:0] evt_count
);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE, S_TIMEOUT} state_t;

  localparam int DRN_W = (HALT_DELAY > 1) ? $clog2(HALT_DELAY) : 1;
  localparam logic [DRN_W-1:0] DRAIN_LOAD = DRN_W'((HALT_DELAY > 0) ? HALT_DELAY - 1 : 0);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t           state, state_nxt;
  logic [DRN_W-1:0] drain_cnt, drain_nxt;
  logic             clear_cnt;
  logic             first_cycle;
  logic             prev_fetch;
  logic             is_fetch;
  logic             active;
  logic [CNT_W-1:0] cyc_cnt;
  logic [CNT_W-1:0] ins_cnt;
  logic [CNT_W-1:0] evt_cnt [N_EVT];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  assign is_fetch = (cpu_state == IFETCH_CODE);
  assign active   = (state == S_RUN) || (state == S_DRAIN);

  always_comb begin
    state_nxt = state;
    drain_nxt = drain_cnt;
    clear_cnt = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_TIMEOUT: begin
        if (start) begin
          state_nxt = S_RUN;
          clear_cnt = 1'b1;
        end
      end
      S_RUN: begin
        // QUIT wins over a timeout landing on the same edge
        if (cpu_state == QUIT_CODE) begin
          if (HALT_DELAY == 0) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_DRAIN;
            drain_nxt = DRAIN_LOAD;
          end
        end else if ((TIMEOUT != 0) && (cyc_cnt == TO_LAST)) begin
          state_nxt = S_TIMEOUT;
        end
      end
      S_DRAIN: begin
        if (drain_cnt == '0) state_nxt = S_DONE;
        else                 drain_nxt = drain_cnt - 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      drain_cnt   <= '0;
      first_cycle <= 1'b0;
      prev_fetch  <= 1'b0;
      cyc_cnt     <= '0;
      ins_cnt     <= '0;
      for (int i = 0; i < N_EVT; i++) evt_cnt[i] <= '0;
    end else begin
      state      <= state_nxt;
      drain_cnt  <= drain_nxt;
      prev_fetch <= is_fetch;
      if (clear_cnt) begin
        first_cycle <= 1'b1;
        cyc_cnt     <= '0;
        ins_cnt     <= '0;
        for (int i = 0; i < N_EVT; i++) evt_cnt[i] <= '0;
      end else if (active) begin
        cyc_cnt <= sat_inc(cyc_cnt);
        for (int i = 0; i < N_EVT; i++) begin
          if (evt[i]) evt_cnt[i] <= sat_inc(evt_cnt[i]);
        end
        // fetches are counted on the rising edge of IFETCH, forced on the first RUN cycle
        if (state == S_RUN) begin
          first_cycle <= 1'b0;
          if (is_fetch && (first_cycle || !prev_fetch)) ins_cnt <= sat_inc(ins_cnt);
        end
      end
    end
  end

  assign running     = active;
  assign done        = (state == S_DONE);
  assign timed_out   = (state == S_TIMEOUT);
  assign halt_req    = (state == S_DONE) || (state == S_TIMEOUT);
  assign cycle_count = cyc_cnt;
  assign instr_count = ins_cnt;

  for (genvar g = 0; g < N_EVT; g++) begin : g_evt_out
    assign evt_count[g*CNT_W +: CNT_W] = evt_cnt[g];
  end

endmodule

// File: tb/tb_albacore_run_monitor.sv
// Bench for albacore_run_monitor: three parameterisations driven in parallel, checked against a run-level model.
module tb_albacore_run_monitor;

  logic       clk;
  logic       reset;
  logic       start;
  logic [4:0] cpu_state;
  logic [1:0] evt;

  logic        run_o [3];
  logic        done_o [3];
  logic        to_o [3];
  logic        halt_o [3];
  logic [31:0] cyc_o [3];
  logic [31:0] ins_o [3];
  logic [63:0] ev_o [3];

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // dut 0: HALT_DELAY=1 TIMEOUT=100, dut 1: HALT_DELAY=0 no timeout, dut 2: HALT_DELAY=3 TIMEOUT=20
  albacore_run_monitor #(.HALT_DELAY(1), .TIMEOUT(100)) dut0 (
    .clk(clk), .reset(reset), .cpu_state(cpu_state), .start(start), .evt(evt),
    .running(run_o[0]), .done(done_o[0]), .timed_out(to_o[0]), .halt_req(halt_o[0]),
    .cycle_count(cyc_o[0]), .instr_count(ins_o[0]), .evt_count(ev_o[0]));
  albacore_run_monitor #(.HALT_DELAY(0), .TIMEOUT(0)) dut1 (
    .clk(clk), .reset(reset), .cpu_state(cpu_state), .start(start), .evt(evt),
    .running(run_o[1]), .done(done_o[1]), .timed_out(to_o[1]), .halt_req(halt_o[1]),
    .cycle_count(cyc_o[1]), .instr_count(ins_o[1]), .evt_count(ev_o[1]));
  albacore_run_monitor #(.HALT_DELAY(3), .TIMEOUT(20)) dut2 (
    .clk(clk), .reset(reset), .cpu_state(cpu_state), .start(start), .evt(evt),
    .running(run_o[2]), .done(done_o[2]), .timed_out(to_o[2]), .halt_req(halt_o[2]),
    .cycle_count(cyc_o[2]), .instr_count(ins_o[2]), .evt_count(ev_o[2]));

  function automatic longint hd_of(int k);
    case (k)
      0: return 1;
      1: return 0;
      default: return 3;
    endcase
  endfunction

  function automatic longint to_of(int k);
    case (k)
      0: return 100;
      1: return 0;
      default: return 20;
    endcase
  endfunction

  // Run-level model: a run is active until the cycle count reaches the QUIT target or the budget
  bit     m_act [3];
  int     m_end [3];   // 0 none, 1 completed, 2 timed out
  longint m_tgt [3];   // cycle count at which the run completes, -1 while QUIT not yet seen
  longint m_cyc [3];
  longint m_ins [3];
  longint m_ev0 [3];
  longint m_ev1 [3];
  bit     m_first [3];
  bit     m_prev_fetch = 0;

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        m_act[k] = 0; m_end[k] = 0; m_tgt[k] = -1; m_first[k] = 0;
        m_cyc[k] = 0; m_ins[k] = 0; m_ev0[k] = 0; m_ev1[k] = 0;
      end else if (m_act[k]) begin
        bit run_edge;
        run_edge = (m_tgt[k] < 0);
        if (run_edge) begin
          if (cpu_state == 5'd0 && (m_first[k] || !m_prev_fetch)) m_ins[k]++;
          m_first[k] = 0;
        end
        m_cyc[k]++;
        if (evt[0]) m_ev0[k]++;
        if (evt[1]) m_ev1[k]++;
        if (run_edge) begin
          if (cpu_state == 5'd18) m_tgt[k] = m_cyc[k] + hd_of(k);
          else if (to_of(k) != 0 && m_cyc[k] == to_of(k)) begin
            m_act[k] = 0; m_end[k] = 2;
          end
        end
        if (m_tgt[k] >= 0 && m_cyc[k] == m_tgt[k]) begin
          m_act[k] = 0; m_end[k] = 1;
        end
      end else if (start) begin
        m_act[k] = 1; m_end[k] = 0; m_tgt[k] = -1; m_first[k] = 1;
        m_cyc[k] = 0; m_ins[k] = 0; m_ev0[k] = 0; m_ev1[k] = 0;
      end
    end
    m_prev_fetch = (cpu_state == 5'd0);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("dut%0d_running", k), 64'(run_o[k]), 64'(m_act[k]));
        chk($sformatf("dut%0d_done", k), 64'(done_o[k]), 64'(!m_act[k] && m_end[k] == 1));
        chk($sformatf("dut%0d_timed_out", k), 64'(to_o[k]), 64'(!m_act[k] && m_end[k] == 2));
        chk($sformatf("dut%0d_halt_req", k), 64'(halt_o[k]), 64'(!m_act[k] && m_end[k] != 0));
        chk($sformatf("dut%0d_cycle_count", k), 64'(cyc_o[k]), m_cyc[k]);
        chk($sformatf("dut%0d_instr_count", k), 64'(ins_o[k]), m_ins[k]);
        chk($sformatf("dut%0d_evt0", k), 64'(ev_o[k][31:0]), m_ev0[k]);
        chk($sformatf("dut%0d_evt1", k), 64'(ev_o[k][63:32]), m_ev1[k]);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1;
    step(1);
    start = 0;
  endtask

  initial begin
    reset = 1; start = 1; cpu_state = 5'd3; evt = 2'b00;
    step(2);
    chk_en = 1;
    chk("reset_running", 64'(run_o[0]), 64'd0);
    chk("reset_halt", 64'(halt_o[0]), 64'd0);
    chk("reset_cycle", 64'(cyc_o[0]), 64'd0);
    reset = 0; start = 0;
    step(3);
    chk("idle_after_reset", 64'(run_o[0]), 64'd0);

    // normal run
    pulse_start();
    chk("start_running", 64'(run_o[0]), 64'd1);
    for (int r = 0; r < 3; r++) begin
      cpu_state = 5'd0;  step(1);
      cpu_state = 5'd1;  step(1);
      cpu_state = 5'd2;  step(1);
      cpu_state = 5'd3;  step(1);
      cpu_state = 5'd22; step(1);
    end
    cpu_state = 5'd18; step(1);
    chk("drain_not_done", 64'(done_o[0]), 64'd0);
    chk("hd0_done_cycle", 64'(cyc_o[1]), 64'd16);
    cpu_state = 5'd3; step(1);
    chk("normal_done", 64'(done_o[0]), 64'd1);
    chk("normal_cycle", 64'(cyc_o[0]), 64'd17);
    chk("normal_instr", 64'(ins_o[0]), 64'd3);
    chk("normal_timed_out", 64'(to_o[0]), 64'd0);
    step(3);
    chk("hd3_cycle", 64'(cyc_o[2]), 64'd19);

    // timeout
    pulse_start();
    step(99);
    chk("pre_timeout_cycle", 64'(cyc_o[0]), 64'd99);
    step(1);
    chk("timeout_flag", 64'(to_o[0]), 64'd1);
    chk("timeout_halt", 64'(halt_o[0]), 64'd1);
    chk("timeout_cycle", 64'(cyc_o[0]), 64'd100);
    chk("timeout_done", 64'(done_o[0]), 64'd0);
    chk("timeout_instr", 64'(ins_o[0]), 64'd0);
    chk("to20_cycle", 64'(cyc_o[2]), 64'd20);

    // QUIT on the timeout edge
    pulse_start();
    step(99);
    cpu_state = 5'd18; step(1);
    cpu_state = 5'd3;  step(1);
    chk("race_done", 64'(done_o[0]), 64'd1);
    chk("race_timed_out", 64'(to_o[0]), 64'd0);
    chk("race_cycle", 64'(cyc_o[0]), 64'd101);

    // reset mid-run
    pulse_start();
    step(40);
    chk("mid_cycle", 64'(cyc_o[0]), 64'd40);
    reset = 1; step(1); reset = 0;
    chk("mid_reset_running", 64'(run_o[0]), 64'd0);
    chk("mid_reset_cycle", 64'(cyc_o[0]), 64'd0);
    pulse_start();
    cpu_state = 5'd18; step(1); cpu_state = 5'd3;
    chk("quick_done", 64'(done_o[1]), 64'd1);
    chk("quick_cycle", 64'(cyc_o[1]), 64'd1);
    chk("quick_instr", 64'(ins_o[1]), 64'd0);

    // events and restart
    reset = 1; step(1); reset = 0;
    evt = 2'b01; step(4); evt = 2'b00;
    pulse_start();
    evt = 2'b10; step(2);
    start = 1; step(1); start = 0;
    step(2); evt = 2'b00;
    step(2);
    chk("evt_ch0", 64'(ev_o[0][31:0]), 64'd0);
    chk("evt_ch1", 64'(ev_o[0][63:32]), 64'd5);
    chk("evt_running", 64'(run_o[0]), 64'd1);
    chk("evt_cycle", 64'(cyc_o[0]), 64'd7);
    cpu_state = 5'd18; step(2); cpu_state = 5'd3;
    chk("evt_done", 64'(done_o[0]), 64'd1);
    pulse_start();
    chk("restart_running", 64'(run_o[0]), 64'd1);
    chk("restart_cycle", 64'(cyc_o[0]), 64'd0);
    chk("restart_evt1", 64'(ev_o[0][63:32]), 64'd0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      int r;
      reset = ($urandom % 300 == 0);
      start = ($urandom % 25 == 0);
      r = $urandom % 100;
      if (r < 30)      cpu_state = 5'd0;
      else if (r < 33) cpu_state = 5'd18;
      else             cpu_state = 5'($urandom % 32);
      evt = 2'($urandom % 4);
      step(1);
    end
    reset = 0; start = 0; evt = 2'b00;
    step(5);
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
